// File: rtl/swerv_types.sv
// Shared types for the branch-statistics counter controller and its read queue.
package swerv_types;

  localparam int CNT_W = 32;

  // One commit-slot counter command; bits below valid are in priority order.
  typedef struct packed {
    logic valid;
    logic bcount_reset;
    logic btcount_reset;
    logic start;
    logic stop;
    logic bcount_read;
    logic btcount_read;
  } brcnt_cmd_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } brcnt_state_t;

  // One buffered read result: originating slot, counter selector, captured value.
  typedef struct packed {
    logic             pipe;
    logic             sel;
    logic [CNT_W-1:0] data;
  } brcnt_rdq_entry_t;

endpackage

// File: rtl/brcnt_rdq.sv
// Two-entry read-result FIFO with ordered dual push, single pop and a sticky drop flag.
module brcnt_rdq
  import swerv_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  brcnt_rdq_entry_t push0_entry,
  input  logic             push1,
  input  brcnt_rdq_entry_t push1_entry,
  input  logic             rd_ready,
  output logic             head_valid,
  output brcnt_rdq_entry_t head_entry,
  output logic [1:0]       count,
  output logic             drop
);

  brcnt_rdq_entry_t mem_q [2];
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             drop_q;

  logic             pop;
  logic [1:0]       n_push;
  logic [1:0]       space;
  logic [1:0]       n_acc;
  logic             drop_set;
  logic             wr_ptr;
  brcnt_rdq_entry_t first_entry;

  // Work out how many of this cycle's pushes fit once the same-cycle pop has freed its slot.
  always_comb begin
    pop         = (cnt_q != 2'd0) && rd_ready;
    n_push      = {1'b0, push0} + {1'b0, push1};
    space       = 2'd2 - cnt_q + {1'b0, pop};
    drop_set    = 1'b0;
    n_acc       = n_push;
    if (n_push > space) begin
      n_acc    = space;
      drop_set = 1'b1;
    end
    first_entry = push0 ? push0_entry : push1_entry;
    wr_ptr      = rd_ptr_q ^ cnt_q[0];
  end

  // Storage, pointers, occupancy and the sticky drop flag; the youngest push is the one lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      if (n_acc != 2'd0) mem_q[wr_ptr] <= first_entry;
      if (n_acc == 2'd2) mem_q[~wr_ptr] <= push1_entry;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_q - {1'b0, pop} + n_acc;
      drop_q   <= drop_q | drop_set;
    end
  end

  assign head_valid = (cnt_q != 2'd0);
  assign head_entry = mem_q[rd_ptr_q];
  assign count      = cnt_q;
  assign drop       = drop_q;

endmodule

// File: rtl/dec_brcount_ctl.sv
// Branch-statistics counter controller: RUN/STOPPED FSM, two wrapping counters and
// in-order evaluation of the i0 then i1 commit slots, with reads buffered in brcnt_rdq.
module dec_brcount_ctl
  import swerv_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  brcnt_cmd_t       i0_cmd,
  input  brcnt_cmd_t       i1_cmd,
  input  logic             i0_br_valid,
  input  logic             i1_br_valid,
  input  logic             i0_br_taken,
  input  logic             i1_br_taken,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_pipe,
  output logic             rd_sel,
  input  logic             rd_ready,
  output logic             busy,
  output logic             running,
  output logic             bcount_ovf,
  output logic             btcount_ovf,
  output logic             rd_drop
);

  brcnt_state_t     state_q, state_n;
  logic [CNT_W-1:0] bcount_q, bcount_n;
  logic [CNT_W-1:0] btcount_q, btcount_n;
  logic             bovf_q, bovf_n;
  logic             btovf_q, btovf_n;

  brcnt_cmd_t       cmd [2];
  logic [1:0]       br_v;
  logic [1:0]       br_t;
  logic [1:0]       push_v;
  brcnt_rdq_entry_t push_e [2];

  brcnt_rdq_entry_t head_entry;
  logic [1:0]       q_count;

  assign cmd[0] = i0_cmd;
  assign cmd[1] = i1_cmd;
  assign br_v   = {i1_br_valid, i0_br_valid};
  assign br_t   = {i1_br_taken, i0_br_taken};

  // Apply i0 then i1 in program order, so the younger slot sees everything the older slot did.
  always_comb begin
    state_n   = state_q;
    bcount_n  = bcount_q;
    btcount_n = btcount_q;
    bovf_n    = bovf_q;
    btovf_n   = btovf_q;
    push_v    = 2'b00;
    push_e[0] = '0;
    push_e[1] = '0;
    for (int s = 0; s < 2; s++) begin
      push_e[s].pipe = 1'(s);
      if (cmd[s].valid) begin
        if (cmd[s].bcount_reset) begin
          bcount_n = '0;
          bovf_n   = 1'b0;
        end else if (cmd[s].btcount_reset) begin
          btcount_n = '0;
          btovf_n   = 1'b0;
        end else if (cmd[s].start) begin
          state_n = RUN;
        end else if (cmd[s].stop) begin
          state_n = STOPPED;
        end else if (cmd[s].bcount_read) begin
          push_v[s]      = 1'b1;
          push_e[s].sel  = 1'b0;
          push_e[s].data = bcount_n;
        end else if (cmd[s].btcount_read) begin
          push_v[s]      = 1'b1;
          push_e[s].sel  = 1'b1;
          push_e[s].data = btcount_n;
        end
      end else if (br_v[s] && (state_n == RUN)) begin
        if (&bcount_n) bovf_n = 1'b1;
        bcount_n = bcount_n + 1'b1;
        if (br_t[s]) begin
          if (&btcount_n) btovf_n = 1'b1;
          btcount_n = btcount_n + 1'b1;
        end
      end
    end
  end

  // RUN/STOPPED state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STOPPED;
    else     state_q <= state_n;
  end

  // Counter values and their sticky wrap flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcount_q  <= '0;
      btcount_q <= '0;
      bovf_q    <= 1'b0;
      btovf_q   <= 1'b0;
    end else begin
      bcount_q  <= bcount_n;
      btcount_q <= btcount_n;
      bovf_q    <= bovf_n;
      btovf_q   <= btovf_n;
    end
  end

  brcnt_rdq u_rdq (
    .clk         (clk),
    .rst         (rst),
    .push0       (push_v[0]),
    .push0_entry (push_e[0]),
    .push1       (push_v[1]),
    .push1_entry (push_e[1]),
    .rd_ready    (rd_ready),
    .head_valid  (rd_valid),
    .head_entry  (head_entry),
    .count       (q_count),
    .drop        (rd_drop)
  );

  assign rd_data     = head_entry.data;
  assign rd_pipe     = head_entry.pipe;
  assign rd_sel      = head_entry.sel;
  assign busy        = (q_count != 2'd0);
  assign running     = (state_q == RUN);
  assign bcount_ovf  = bovf_q;
  assign btcount_ovf = btovf_q;

endmodule
